// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter (round-robin or port-0 priority) with lock hold; grant and memory strobes are combinational.
// Responses land exactly one cycle after the grant; a requester that loses simply holds req until gnt, with no other backpressure.
module dmem_arbiter #(
   parameter int RR_EN = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_0,
   input  logic        we_0,
   input  logic        lock_0,
   input  logic [31:0] addr_0,
   input  logic [31:0] wdata_0,
   output logic        gnt_0,
   output logic        rvalid_0,
   output logic        err_0,
   output logic [31:0] rdata_0,
   input  logic        req_1,
   input  logic        we_1,
   input  logic        lock_1,
   input  logic [31:0] addr_1,
   input  logic [31:0] wdata_1,
   output logic        gnt_1,
   output logic        rvalid_1,
   output logic        err_1,
   output logic [31:0] rdata_1,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   output logic        mem_write_enable,
   output logic        mem_read_enable,
   input  logic [31:0] mem_read_data
);

   typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_t;

   state_t      state, state_nxt;
   logic        last_grant;
   logic        g0, g1, gnt_any;
   logic        sel_we, legal;
   logic [31:0] sel_addr;
   logic [1:0]  rvalid_q, err_q, rd_q;

   always_comb begin
      g0        = 1'b0;
      g1        = 1'b0;
      state_nxt = state;
      case (state)
         LOCK0: begin
            g0 = req_0;
            if (!lock_0) state_nxt = ARB;
         end
         LOCK1: begin
            g1 = req_1;
            if (!lock_1) state_nxt = ARB;
         end
         default: begin
            if (req_0 && req_1) begin
               // last_grant==0 means port 0 won most recently
               if ((RR_EN != 0) && !last_grant) g1 = 1'b1;
               else                             g0 = 1'b1;
            end else begin
               g0 = req_0;
               g1 = req_1;
            end
            if (g0 && lock_0)      state_nxt = LOCK0;
            else if (g1 && lock_1) state_nxt = LOCK1;
         end
      endcase
      if (!rst_n) begin
         g0 = 1'b0;
         g1 = 1'b0;
      end
   end

   assign gnt_0   = g0;
   assign gnt_1   = g1;
   assign gnt_any = g0 | g1;

   assign sel_addr = g1 ? addr_1 : addr_0;
   assign sel_we   = g1 ? we_1   : we_0;
   assign legal    = (sel_addr[1:0] == 2'b00) && (sel_addr[31:10] == 22'd0);

   assign mem_address      = sel_addr;
   assign mem_write_data   = g1 ? wdata_1 : wdata_0;
   assign mem_write_enable = gnt_any & legal & sel_we;
   assign mem_read_enable  = gnt_any & legal & ~sel_we;

   // Response owner and kind are captured at grant so next-cycle requests cannot reroute rdata.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ARB;
         last_grant <= 1'b1;
         rvalid_q   <= 2'b00;
         err_q      <= 2'b00;
         rd_q       <= 2'b00;
      end else begin
         state <= state_nxt;
         if (gnt_any) last_grant <= g1;
         rvalid_q <= {g1, g0};
         err_q    <= {g1 & ~legal, g0 & ~legal};
         rd_q     <= {g1 & legal & ~sel_we, g0 & legal & ~sel_we};
      end
   end

   assign rvalid_0 = rvalid_q[0];
   assign rvalid_1 = rvalid_q[1];
   assign err_0    = err_q[0];
   assign err_1    = err_q[1];
   assign rdata_0  = rd_q[0] ? mem_read_data : 32'd0;
   assign rdata_1  = rd_q[1] ? mem_read_data : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a round-robin and a fixed-priority instance share stimulus, each with its own memory.
// Expected results come from a transaction-level model of ownership, last winner and memory contents.
module tb_dmem_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        req_0, we_0, lock_0, req_1, we_1, lock_1;
   logic [31:0] addr_0, wdata_0, addr_1, wdata_1;

   logic [1:0]  gnt0, gnt1, rv0, rv1, er0, er1, mwe, mre;
   logic [31:0] rd0 [2];
   logic [31:0] rd1 [2];
   logic [31:0] maddr [2];
   logic [31:0] mwd [2];
   logic [31:0] mrd [2];

   logic [31:0] mem [2][256];
   bit          loaded;

   int total = 0;
   int bad   = 0;

   // model state: index 0 = round-robin instance, 1 = fixed-priority instance
   int          owner [2];
   int          lastg [2];
   bit          pv [2][2];
   bit          pe [2][2];
   logic [31:0] pd [2][2];
   logic [31:0] mm [2][256];

   dmem_arbiter #(.RR_EN(1)) u_rr (
      .clk(clk), .rst_n(rst_n),
      .req_0(req_0), .we_0(we_0), .lock_0(lock_0), .addr_0(addr_0), .wdata_0(wdata_0),
      .gnt_0(gnt0[0]), .rvalid_0(rv0[0]), .err_0(er0[0]), .rdata_0(rd0[0]),
      .req_1(req_1), .we_1(we_1), .lock_1(lock_1), .addr_1(addr_1), .wdata_1(wdata_1),
      .gnt_1(gnt1[0]), .rvalid_1(rv1[0]), .err_1(er1[0]), .rdata_1(rd1[0]),
      .mem_address(maddr[0]), .mem_write_data(mwd[0]), .mem_write_enable(mwe[0]),
      .mem_read_enable(mre[0]), .mem_read_data(mrd[0])
   );

   dmem_arbiter #(.RR_EN(0)) u_fp (
      .clk(clk), .rst_n(rst_n),
      .req_0(req_0), .we_0(we_0), .lock_0(lock_0), .addr_0(addr_0), .wdata_0(wdata_0),
      .gnt_0(gnt0[1]), .rvalid_0(rv0[1]), .err_0(er0[1]), .rdata_0(rd0[1]),
      .req_1(req_1), .we_1(we_1), .lock_1(lock_1), .addr_1(addr_1), .wdata_1(wdata_1),
      .gnt_1(gnt1[1]), .rvalid_1(rv1[1]), .err_1(er1[1]), .rdata_1(rd1[1]),
      .mem_address(maddr[1]), .mem_write_data(mwd[1]), .mem_write_enable(mwe[1]),
      .mem_read_enable(mre[1]), .mem_read_data(mrd[1])
   );

   function automatic logic [31:0] init_word(input int j);
      if (j == 4) return 32'hDEADBEEF;
      return (32'(j) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
   endfunction

   // 256x32 synchronous memories, one-cycle read latency
   always @(posedge clk) begin
      if (!loaded) begin
         for (int k = 0; k < 2; k++)
            for (int j = 0; j < 256; j++) mem[k][j] = init_word(j);
         loaded = 1'b1;
      end
      for (int k = 0; k < 2; k++) begin
         if (mre[k]) mrd[k] <= mem[k][maddr[k][9:2]];
         if (mwe[k]) mem[k][maddr[k][9:2]] = mwd[k];
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         owner[i] = -1;
         lastg[i] = 1;
         for (int p = 0; p < 2; p++) begin
            pv[i][p] = 1'b0;
            pe[i][p] = 1'b0;
            pd[i][p] = 32'd0;
         end
      end
   endtask

   task automatic check_cycle();
      for (int i = 0; i < 2; i++) begin
         int          g;
         bit          lg, w, lk;
         logic [31:0] a, d;
         g = -1;
         if (owner[i] == 0) begin
            if (req_0) g = 0;
         end else if (owner[i] == 1) begin
            if (req_1) g = 1;
         end else if (req_0 && req_1) begin
            g = (i == 0 && lastg[i] == 0) ? 1 : 0;
         end else if (req_0) g = 0;
         else if (req_1) g = 1;

         a  = (g == 1) ? addr_1  : addr_0;
         d  = (g == 1) ? wdata_1 : wdata_0;
         w  = (g == 1) ? we_1    : we_0;
         lk = (g == 1) ? lock_1  : lock_0;
         lg = (a[1:0] == 2'b00) && (a < 32'd1024);

         chk($sformatf("gnt_0[%0d]", i), 32'(gnt0[i]), 32'(g == 0));
         chk($sformatf("gnt_1[%0d]", i), 32'(gnt1[i]), 32'(g == 1));
         chk($sformatf("mem_we[%0d]", i), 32'(mwe[i]), 32'(g >= 0 && lg && w));
         chk($sformatf("mem_re[%0d]", i), 32'(mre[i]), 32'(g >= 0 && lg && !w));
         if (g >= 0 && lg) begin
            chk($sformatf("mem_addr[%0d]", i), maddr[i], a);
            if (w) chk($sformatf("mem_wdata[%0d]", i), mwd[i], d);
         end
         chk($sformatf("rvalid_0[%0d]", i), 32'(rv0[i]), 32'(pv[i][0]));
         chk($sformatf("err_0[%0d]", i),    32'(er0[i]), 32'(pe[i][0]));
         chk($sformatf("rdata_0[%0d]", i),  rd0[i],      pd[i][0]);
         chk($sformatf("rvalid_1[%0d]", i), 32'(rv1[i]), 32'(pv[i][1]));
         chk($sformatf("err_1[%0d]", i),    32'(er1[i]), 32'(pe[i][1]));
         chk($sformatf("rdata_1[%0d]", i),  rd1[i],      pd[i][1]);

         for (int p = 0; p < 2; p++) begin
            pv[i][p] = 1'b0;
            pe[i][p] = 1'b0;
            pd[i][p] = 32'd0;
         end
         if (g >= 0) begin
            pv[i][g] = 1'b1;
            pe[i][g] = !lg;
            pd[i][g] = (lg && !w) ? mm[i][a[9:2]] : 32'd0;
            if (lg && w) mm[i][a[9:2]] = d;
            lastg[i] = g;
         end
         if (owner[i] < 0) begin
            if (g >= 0 && lk) owner[i] = g;
         end else if (!((owner[i] == 0) ? lock_0 : lock_1)) begin
            owner[i] = -1;
         end
      end
   endtask

   task automatic drv(input bit r0, input bit w0, input bit l0, input logic [31:0] a0, input logic [31:0] d0,
                      input bit r1, input bit w1, input bit l1, input logic [31:0] a1, input logic [31:0] d1);
      req_0 = r0; we_0 = w0; lock_0 = l0; addr_0 = a0; wdata_0 = d0;
      req_1 = r1; we_1 = w1; lock_1 = l1; addr_1 = a1; wdata_1 = d1;
   endtask

   task automatic idle();
      drv(0, 0, 0, 32'd0, 32'd0, 0, 0, 0, 32'd0, 32'd0);
   endtask

   task automatic step();
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      drv(1, 0, 1, 32'h10, 32'd0, 1, 1, 1, 32'h14, 32'h1);
      #2;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("rst_gnt_0[%0d]", i), 32'(gnt0[i]), 32'd0);
         chk($sformatf("rst_gnt_1[%0d]", i), 32'(gnt1[i]), 32'd0);
         chk($sformatf("rst_mem_en[%0d]", i), 32'(mre[i] | mwe[i]), 32'd0);
         chk($sformatf("rst_rvalid[%0d]", i), 32'(rv0[i] | rv1[i]), 32'd0);
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle();
   endtask

   function automatic logic [31:0] raddr();
      int          k = $urandom_range(9);
      logic [31:0] w = 32'($urandom_range(255)) << 2;
      if (k == 0) return $urandom;
      if (k == 1) return w | 32'($urandom_range(3, 1));
      return w;
   endfunction

   initial begin
      for (int k = 0; k < 2; k++)
         for (int j = 0; j < 256; j++) mm[k][j] = init_word(j);
      do_reset();
      step();

      // single read of word 4
      drv(1, 0, 0, 32'h10, 32'd0, 0, 0, 0, 32'd0, 32'd0);
      step();
      idle();
      step();

      // both ports contending for four cycles from reset
      do_reset();
      for (int n = 0; n < 4; n++) begin
         drv(1, 0, 0, 32'(n) << 2, 32'd0, 1, 0, 0, 32'h100 + (32'(n) << 2), 32'd0);
         step();
      end
      idle();
      step();

      // port 1 locked write, then contention while locked, then unlock
      do_reset();
      drv(0, 0, 0, 32'd0, 32'd0, 1, 1, 1, 32'h40, 32'hCAFE_0001);
      step();
      drv(1, 0, 0, 32'h44, 32'd0, 1, 1, 1, 32'h48, 32'hCAFE_0002);
      step();
      drv(1, 0, 0, 32'h44, 32'd0, 1, 1, 0, 32'h4C, 32'hCAFE_0003);
      step();
      drv(1, 0, 0, 32'h40, 32'd0, 1, 0, 0, 32'h48, 32'd0);
      step();
      idle();
      step();

      // misaligned write and out-of-range read
      drv(1, 1, 0, 32'h2, 32'h1234_5678, 0, 0, 0, 32'd0, 32'd0);
      step();
      drv(1, 0, 0, 32'h400, 32'd0, 0, 0, 0, 32'd0, 32'd0);
      step();
      idle();
      step();

      // reset in the response cycle of a locked read
      drv(1, 0, 1, 32'h20, 32'd0, 0, 0, 0, 32'd0, 32'd0);
      step();
      chk("pre_rst_rvalid_0", 32'(rv0[0]), 32'd1);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("mid_rst_rvalid_0", 32'(rv0[0]), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drv(0, 0, 0, 32'd0, 32'd0, 1, 0, 0, 32'h30, 32'd0);
      step();
      idle();
      step();

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         drv(1'($urandom_range(1)), 1'($urandom_range(1)), ($urandom_range(3) == 0), raddr(), $urandom,
             1'($urandom_range(1)), 1'($urandom_range(1)), ($urandom_range(3) == 0), raddr(), $urandom);
         step();
      end
      idle();
      step();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
